// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding and sine-table geometry for the PWM datapath
package pwm_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, GAP = 2'd2} state_e;
  localparam int DEF_THETA_W   = 10;
  localparam int DEF_THETA_MAX = 88;
endpackage

// File: rtl/pwm_sine_sequencer_tick_div.sv
// pwm_tick_div: programmable divider that counts 0..div_i-1 and pulses tick_o on the last count
module pwm_tick_div #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] div_i,
  output logic         tick_o
);
  logic [W-1:0] cnt_q;
  assign tick_o = en_i && cnt_q == div_i - W'(1);
  always_ff @(posedge clk)
    if (!rst_n || clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= tick_o ? '0 : cnt_q + W'(1);
endmodule

// File: rtl/pwm_sine_sequencer.sv
// pwm_sine_sequencer: start/stop FSM stepping the sine phase index in bursts of sweeps with idle gaps
module pwm_sine_sequencer import pwm_pkg::*; #(
  parameter int THETA_W   = DEF_THETA_W,
  parameter int THETA_MAX = DEF_THETA_MAX,
  parameter int DIV_W     = 32,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [DIV_W-1:0]   step_div,
  input  logic [CNT_W-1:0]   sweep_count,
  input  logic [DIV_W-1:0]   gap_cycles,
  input  logic               repeat_en,
  output logic [THETA_W-1:0] theta,
  output logic               pwm_en,
  output logic               busy,
  output logic               burst_done,
  output logic [1:0]         state_o
);
  state_e             state_q;
  logic [THETA_W-1:0] theta_q;
  logic               pwm_q, busy_q, done_q, rep_q;
  logic [CNT_W-1:0]   sweeps_q, sweep_n_q;
  logic [DIV_W-1:0]   div_q, gap_q;
  logic               step_tick, gap_tick, last_theta, sweep_end;

  assign last_theta = theta_q == THETA_W'(THETA_MAX);
  assign sweep_end  = sweep_n_q != '0 && sweeps_q + CNT_W'(1) == sweep_n_q;
  assign theta      = theta_q;
  assign pwm_en     = pwm_q;
  assign busy       = busy_q;
  assign burst_done = done_q;
  assign state_o    = state_q;

  pwm_tick_div #(.W(DIV_W)) u_step (
    .clk(clk), .rst_n(rst_n), .clr_i(state_q != RUN), .en_i(state_q == RUN),
    .div_i(div_q), .tick_o(step_tick)
  );

  pwm_tick_div #(.W(DIV_W)) u_gap (
    .clk(clk), .rst_n(rst_n), .clr_i(state_q != GAP), .en_i(state_q == GAP),
    .div_i(gap_q), .tick_o(gap_tick)
  );

  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q   <= IDLE;
      theta_q   <= '0;
      pwm_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rep_q     <= 1'b0;
      sweeps_q  <= '0;
      sweep_n_q <= '0;
      div_q     <= '0;
      gap_q     <= '0;
    end else begin
      done_q <= 1'b0;
      // stop overrides everything, including a sweep ending this cycle
      if (state_q != IDLE && stop) begin
        state_q <= IDLE;
        theta_q <= '0;
        pwm_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else
        case (state_q)
          IDLE:
            if (start && !stop) begin
              state_q   <= RUN;
              theta_q   <= '0;
              pwm_q     <= 1'b1;
              busy_q    <= 1'b1;
              sweeps_q  <= '0;
              div_q     <= step_div == '0 ? DIV_W'(1) : step_div;
              sweep_n_q <= sweep_count;
              gap_q     <= gap_cycles;
              rep_q     <= repeat_en;
            end
          RUN:
            if (step_tick) begin
              if (!last_theta) theta_q <= theta_q + THETA_W'(1);
              else begin
                theta_q <= '0;
                if (sweep_end) begin
                  done_q   <= 1'b1;
                  sweeps_q <= '0;
                  if (!rep_q) begin
                    state_q <= IDLE;
                    pwm_q   <= 1'b0;
                    busy_q  <= 1'b0;
                  end else if (gap_q != '0) begin
                    state_q <= GAP;
                    pwm_q   <= 1'b0;
                  end
                end else sweeps_q <= sweeps_q + CNT_W'(sweeps_q != '1);
              end
            end
          GAP:
            if (gap_tick) begin
              state_q <= RUN;
              pwm_q   <= 1'b1;
            end
          default: state_q <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_pwm_sine_sequencer.sv
// tb_pwm_sine_sequencer: scoreboard bench, expected output snapshots queued per cycle and checked by a monitor
module tb_pwm_sine_sequencer;
  logic        clk = 1'b0, rst_n, start, stop, repeat_en;
  logic [31:0] step_div, gap_cycles;
  logic [15:0] sweep_count;
  logic [9:0]  theta;
  logic        pwm_en, busy, burst_done;
  logic [1:0]  state_o;

  typedef struct {
    int         cyc;
    logic [9:0] th;
    logic       pw, bs, dn;
    logic [1:0] st;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0, checks = 0, failures = 0, n_done = 0, exp_done = 0, s;
  logic end_flag = 1'b0, end_done = 1'b0;

  pwm_sine_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step_div(step_div),
    .sweep_count(sweep_count), .gap_cycles(gap_cycles), .repeat_en(repeat_en),
    .theta(theta), .pwm_en(pwm_en), .busy(busy), .burst_done(burst_done), .state_o(state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (burst_done === 1'b1) n_done++;
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc || {theta, pwm_en, busy, burst_done, state_o} !== {e.th, e.pw, e.bs, e.dn, e.st}) begin
        failures++;
        $display("FAIL %s cyc=%0d/%0d got theta=%0d pwm=%b busy=%b done=%b st=%0d want theta=%0d pwm=%b busy=%b done=%b st=%0d",
                 e.nm, cyc, e.cyc, theta, pwm_en, busy, burst_done, state_o, e.th, e.pw, e.bs, e.dn, e.st);
      end
    end
    if (end_flag && !end_done) begin
      end_done = 1'b1;
      checks += 2;
      if (q.size() != 0) begin
        failures++;
        $display("FAIL queue_drain pending=%0d want 0", q.size());
      end
      if (n_done != exp_done) begin
        failures++;
        $display("FAIL burst_done_count got=%0d want=%0d", n_done, exp_done);
      end
    end
  end

  task automatic expect_at(input int c, input int th, input logic pw, input logic bs,
                           input logic dn, input int st, input string nm);
    exp_t e;
    e.cyc = c; e.th = 10'(th); e.pw = pw; e.bs = bs; e.dn = dn; e.st = 2'(st); e.nm = nm;
    q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // issue start, then scramble the config inputs to prove they were latched
  task automatic do_start(input logic [31:0] dv, input logic [15:0] sc, input logic [31:0] gp, input logic rp);
    step_div = dv; sweep_count = sc; gap_cycles = gp; repeat_en = rp; start = 1'b1;
    @(negedge clk);
    start = 1'b0; step_div = 9; sweep_count = 7; gap_cycles = 3; repeat_en = ~rp;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; repeat_en = 1'b0;
    step_div = 0; sweep_count = 0; gap_cycles = 0;
    repeat (2) @(negedge clk);
    expect_at(cyc + 1, 0, 0, 0, 0, 0, "reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    s = cyc;
    expect_at(s + 1,   0,  1, 1, 0, 1, "t1_first");
    expect_at(s + 42,  41, 1, 1, 0, 1, "t1_theta41");
    expect_at(s + 60,  59, 1, 1, 0, 1, "t1_start_busy_ignored");
    expect_at(s + 89,  88, 1, 1, 0, 1, "t1_sweep1_end");
    expect_at(s + 90,  0,  1, 1, 0, 1, "t1_wrap");
    expect_at(s + 178, 88, 1, 1, 0, 1, "t1_last_step");
    expect_at(s + 179, 0,  0, 0, 1, 0, "t1_burst_done");
    expect_at(s + 180, 0,  0, 0, 0, 0, "t1_done_one_cycle");
    do_start(1, 2, 0, 0);
    wait_until(s + 50);
    start = 1'b1; step_div = 5; sweep_count = 1;
    @(negedge clk);
    start = 1'b0;
    wait_until(s + 182);
    exp_done = 1;

    s = cyc;
    expect_at(s + 1,   0,  1, 1, 0, 1, "t2_first");
    expect_at(s + 3,   0,  1, 1, 0, 1, "t2_hold3");
    expect_at(s + 4,   1,  1, 1, 0, 1, "t2_step1");
    expect_at(s + 267, 88, 1, 1, 0, 1, "t2_last_step");
    expect_at(s + 268, 0,  0, 1, 1, 2, "t2_gap_done");
    expect_at(s + 272, 0,  0, 1, 0, 2, "t2_gap_last");
    expect_at(s + 273, 0,  1, 1, 0, 1, "t2_rerun");
    expect_at(s + 276, 1,  1, 1, 0, 1, "t2_rerun_step");
    expect_at(s + 540, 0,  0, 1, 1, 2, "t2_gap_done2");
    expect_at(s + 543, 0,  0, 0, 0, 0, "t2_stop_in_gap");
    do_start(3, 1, 5, 1);
    wait_until(s + 542);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_until(s + 545);
    exp_done = 3;

    s = cyc;
    expect_at(s + 45, 44, 1, 1, 0, 1, "t3_div0_theta44");
    expect_at(s + 89, 88, 1, 1, 0, 1, "t3_div0_last");
    expect_at(s + 90, 0,  0, 0, 1, 0, "t3_div0_done");
    do_start(0, 1, 0, 0);
    wait_until(s + 92);
    exp_done = 4;

    s = cyc;
    expect_at(s + 1, 0, 0, 0, 0, 0, "t4_start_stop_idle");
    expect_at(s + 2, 0, 0, 0, 0, 0, "t4_still_idle");
    step_div = 1; sweep_count = 1; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    wait_until(s + 3);

    s = cyc;
    expect_at(s + 89, 88, 1, 1, 0, 1, "t5_final_step");
    expect_at(s + 90, 0,  0, 0, 0, 0, "t5_stop_no_done");
    expect_at(s + 91, 0,  0, 0, 0, 0, "t5_idle");
    do_start(1, 1, 0, 0);
    wait_until(s + 89);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_until(s + 92);

    s = cyc;
    expect_at(s + 1069, 0,  1, 1, 0, 1, "t6_wrap12");
    expect_at(s + 1157, 88, 1, 1, 0, 1, "t6_theta88");
    expect_at(s + 1158, 0,  1, 1, 0, 1, "t6_wrap13");
    expect_at(s + 1200, 42, 1, 1, 0, 1, "t6_theta42");
    expect_at(s + 1202, 0,  0, 0, 0, 0, "t6_stop");
    do_start(1, 0, 0, 0);
    wait_until(s + 1201);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_until(s + 1204);

    s = cyc;
    expect_at(s + 41, 40, 1, 1, 0, 1, "t7_theta40");
    expect_at(s + 42, 0,  0, 0, 0, 0, "t7_reset_mid_run");
    expect_at(s + 43, 0,  0, 0, 0, 0, "t7_after_reset");
    do_start(1, 0, 0, 0);
    wait_until(s + 41);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_until(s + 44);

    end_flag = 1'b1;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pwm_sine_sequencer.md
Name: pwm_sine_sequencer

Overview:
- Controller that sequences the sine-PWM datapath.
- Steps the sine-table phase index (theta, 0..THETA_MAX) at a programmable rate and counts completed half-sine sweeps.
- Runs bursts of N sweeps separated by programmable idle gaps; during a gap the PWM output is forced low.
- Sits between the host/config logic and the PWM comparator plus sine LUT; replaces the free-running divider/delay logic with a start/stop-controlled state machine.

Parameters:
- THETA_W, 10, width of the phase index.
- THETA_MAX, 88, last table entry; the sweep runs 0..THETA_MAX inclusive.
- DIV_W, 32, width of the step divider and gap counter.
- CNT_W, 16, width of the sweep counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request to begin a burst sequence
- stop  in  1  one-cycle request to abort and return to idle
- step_div  in  DIV_W  clocks per theta step; 0 is treated as 1
- sweep_count  in  CNT_W  sweeps per burst; 0 means run until stop
- gap_cycles  in  DIV_W  idle clocks between bursts
- repeat_en  in  1  1 = loop burst/gap forever; 0 = one burst then idle
- theta  out  THETA_W  phase index to the sine LUT
- pwm_en  out  1  1 = comparator drives PWM; 0 = PWM forced low
- busy  out  1  high in any state other than IDLE
- burst_done  out  1  one-cycle pulse when a burst completes
- state_o  out  2  current state for debug (IDLE=0, RUN=1, GAP=2)

Behaviour:
- All outputs are registered. Reset (rst_n=0 at a clk edge) gives: state IDLE, theta=0, pwm_en=0, busy=0, burst_done=0, all counters 0. Reset mid-operation takes effect at that edge with no drain.
- Config latch: step_div, sweep_count, gap_cycles and repeat_en are captured on the accepted start. Input changes while busy have no effect until the next start.
- IDLE:
  - start=1 and stop=0 -> next cycle RUN, theta=0, pwm_en=1, busy=1, divider=0, sweep counter=0.
  - start while busy is ignored.
  - start and stop in the same cycle: stop wins; the block stays or goes to IDLE.
- RUN:
  - Divider counts 0..eff_div-1, where eff_div = max(step_div,1).
  - At divider terminal: if theta<THETA_MAX, theta+1; else theta wraps to 0 and the sweep counter increments.
  - With step_div=1, theta changes every cycle; one sweep is (THETA_MAX+1)*eff_div clocks (89 by default).
  - Sweep end with the incremented count equal to sweep_count (sweep_count≠0):
    - burst_done pulses for 1 cycle, coincident with the transition.
    - repeat_en=1 and gap_cycles>0 -> GAP.
    - repeat_en=1 and gap_cycles=0 -> stay in RUN; sweep counter=0, theta=0.
    - repeat_en=0 -> IDLE.
  - sweep_count=0: the sweep counter saturates at all-ones; the burst never ends and no burst_done is issued.
- GAP:
  - pwm_en=0, theta held at 0, busy=1.
  - Gap counter runs 0..gap_cycles-1; at terminal -> RUN, divider=0, sweep counter=0, pwm_en=1.
- stop in any non-IDLE state -> IDLE next cycle: theta=0, pwm_en=0, busy=0, and no burst_done, even if a sweep ended in the same cycle.
- Width rules: counters are unsigned; the theta wrap uses an equality compare with THETA_MAX, never modulo; no overflow is possible by construction.

Decomposition:
- Shared package pwm_pkg holds:
  - state enum (IDLE, RUN, GAP) and its 2-bit encoding;
  - THETA_W and THETA_MAX defaults, shared with the sine LUT and comparator so the table length and the sweep stay consistent.
- One natural sub-module, pwm_tick_div: a programmable divider with clear and enable that emits a terminal pulse. It is instantiated twice, for the step divider and the gap counter. The FSM stays in the top level.

Test Plan:
- Reset mid-RUN (theta=40): assert rst_n=0 for 1 cycle -> next cycle theta=0, pwm_en=0, busy=0, state_o=0.
- start with step_div=1, sweep_count=2, repeat_en=0 -> theta runs 0..88 twice (178 RUN cycles); burst_done is high for exactly 1 cycle at the end; then busy=0, theta=0.
- step_div=3, sweep_count=1, repeat_en=1, gap_cycles=5 -> each theta value held for 3 clocks; after 267 RUN cycles, burst_done pulses, 5 cycles with pwm_en=0, then RUN restarts at theta=0; the pattern repeats.
- step_div=0, sweep_count=1 -> behaves identically to step_div=1 (89-cycle sweep).
- start and stop in the same cycle from IDLE -> stays IDLE; stop at the final sweep step -> IDLE with no burst_done; start while busy -> ignored, theta sequence undisturbed.
- sweep_count=0, step_div=1 -> RUN for more than 1000 cycles with no burst_done, theta wrapping 88->0 repeatedly; stop -> IDLE next cycle.
